// File: rtl/gpu_pkg.sv
// Shared types and opcode field layout for the 2D GPU command path.
// Opcode layout: [95:92] shape, [91:76] color, [75:0] four 19-bit coords.
package gpu_pkg;

  localparam int COLOR_W   = 16;
  localparam int COORD_W   = 19;
  localparam int OPCODE_W  = 96;
  localparam int SHAPE_MSB = 95;
  localparam int COLOR_MSB = 91;
  localparam int SHAPE_W   = SHAPE_MSB - COLOR_MSB;

  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_LINE     = 4'd0,
    SHAPE_TRIANGLE = 4'd1,
    SHAPE_CIRCLE   = 4'd2
  } shape_t;

  // Shape codes are dense from zero, so legality is a single upper bound.
  function automatic logic shape_legal(input logic [SHAPE_W-1:0] code);
    return code <= SHAPE_CIRCLE;
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled opcodes.
// Occupancy is tracked in its own counter, so the pointers never need an extra wrap bit.
module opcode_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/opcode_assembler.sv
// Packs three host words into one opcode, drops illegal shapes with an error pulse,
// and queues legal opcodes for opdecode behind a valid/ready handshake.
module opcode_assembler #(
  parameter int WORD_W   = 32,
  parameter int OPCODE_W = 96,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [OPCODE_W-1:0]      opcode,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_bad_shape
);

  import gpu_pkg::*;

  localparam int HI_W  = OPCODE_W - WORD_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]          word_cnt_q, word_cnt_d;
  logic [HI_W-1:0]     asm_q, asm_d;
  logic                err_q, err_d;
  logic                accept, complete, legal, push, pop;
  logic [OPCODE_W-1:0] push_data;

  // Only the third word can stall; it depends on registered state alone.
  assign wr_ready  = (word_cnt_q != 2'd2) || (fifo_count < CNT_W'(DEPTH));
  assign accept    = wr_en && wr_ready && !flush;
  assign complete  = accept && (word_cnt_q == 2'd2);
  assign legal     = shape_legal(asm_q[SHAPE_MSB-WORD_W -: SHAPE_W]);
  assign push      = complete && legal;
  assign pop       = op_valid && op_ready && !flush;
  assign push_data = {asm_q, wr_data};

  always_comb begin
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    err_d      = complete && !legal;
    if (accept) begin
      case (word_cnt_q)
        2'd0: begin
          asm_d[HI_W-1 -: WORD_W] = wr_data;
          word_cnt_d              = 2'd1;
        end
        2'd1: begin
          asm_d[WORD_W-1:0] = wr_data;
          word_cnt_d        = 2'd2;
        end
        default: word_cnt_d = 2'd0;
      endcase
    end
    if (flush) begin
      word_cnt_d = 2'd0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= 2'd0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
    end
  end

  opcode_fifo #(
    .WIDTH (OPCODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (opcode),
    .count_o (fifo_count)
  );

  assign op_valid      = (fifo_count != '0);
  assign err_bad_shape = err_q;

endmodule
